// File: rtl/tdm_pkg.sv
// Shared definitions for the TDM serial demultiplexer.
//   - Default channel count and slot width.
//   - FSM state encoding: IDLE hunts for frame_sync, RECV deserialises a frame.
// Optional feature macro (consumed by tdm_demux): TDM_PARITY_EN.
package tdm_pkg;

  localparam int DEF_N_CH = 4;
  localparam int DEF_W    = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } tdm_state_e;

endpackage

// File: rtl/sipo_shift.sv
// W-bit serial-in parallel-out shift register, MSB first.
// A new bit enters at q[0]; after W enabled shifts q[W-1] holds the first bit.
// Ports:
//   clk, rst_n : system clock, asynchronous active-low reset
//   en         : shift sin in this cycle
//   clr        : synchronous clear, has priority over en
//   sin        : serial input bit
//   q          : parallel contents
module sipo_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic         sin,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= {q[W-2:0], sin};
    end
  end

endmodule

// File: rtl/tdm_demux.sv
// Serial time-division demultiplexer (receive end of the TDM link).
// frame_sync (qualified by sdi_valid) marks the first bit of slot 0. Each slot
// of W bits (MSB first) is routed to channel register k, which holds until the
// same slot of a later frame completes.
// Handshake: there is no back-pressure. A line bit is consumed on every cycle
// where sdi_valid is high; when it is low, sdi and frame_sync are ignored and
// no state changes.
// Ports:
//   clk, rst_n  : system clock, asynchronous active-low reset
//   sdi         : serial data bit
//   sdi_valid   : sdi carries a line bit this cycle
//   frame_sync  : start of frame marker (slot 0, bit 0)
//   ch_data     : channel k at [k*W +: W]
//   ch_valid    : one-cycle pulse per channel update
//   frame_done  : one-cycle pulse together with the last channel's ch_valid
//   sync_err    : one-cycle pulse, frame_sync seen mid-frame
//   parity_err  : (TDM_PARITY_EN only) pulse with ch_valid on even-parity mismatch
// Optional feature macro: TDM_PARITY_EN -- each slot carries W data bits
// followed by one even-parity bit.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int N_CH = DEF_N_CH,
  parameter int W    = DEF_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sdi,
  input  logic              sdi_valid,
  input  logic              frame_sync,
  output logic [N_CH*W-1:0] ch_data,
  output logic [N_CH-1:0]   ch_valid,
  output logic              frame_done,
`ifdef TDM_PARITY_EN
  output logic              sync_err,
  output logic              parity_err
`else
  output logic              sync_err
`endif
);

`ifdef TDM_PARITY_EN
  localparam int SLOT_BITS = W + 1;
`else
  localparam int SLOT_BITS = W;
`endif
  localparam int BCW = $clog2(SLOT_BITS);
  localparam int SCW = $clog2(N_CH);

  localparam logic [BCW-1:0] LAST_BIT  = BCW'(SLOT_BITS - 1);
  localparam logic [SCW-1:0] LAST_SLOT = SCW'(N_CH - 1);

  tdm_state_e     state;
  logic [BCW-1:0] bit_cnt;   // index of the next line bit within its slot
  logic [SCW-1:0] slot_cnt;  // index of the slot currently being received

  logic [W-1:0] shift_q;
  logic [W-1:0] slot_word;
  logic         sync_bit;
  logic         data_bit;
  logic         shift_en;
  logic         shift_clr;

  // The sync bit is always slot 0 bit 0, independent of the counters.
  assign sync_bit = sdi_valid && frame_sync;

`ifdef TDM_PARITY_EN
  // The trailing parity bit is checked, never shifted in.
  assign data_bit  = bit_cnt < BCW'(W);
  // At the parity bit the shift register already holds all W data bits.
  assign slot_word = shift_q;
`else
  assign data_bit  = 1'b1;
  // The last data bit is sampled straight from the line so the channel
  // register updates on the same edge that samples it.
  assign slot_word = {shift_q[W-2:0], sdi};
  logic unused_msb;
  assign unused_msb = shift_q[W-1];
`endif

  assign shift_en  = sync_bit || (sdi_valid && state == ST_RECV && data_bit);
  // Keep the shifter clean while hunting so stale line noise never lingers.
  assign shift_clr = sdi_valid && !frame_sync && state == ST_IDLE;

  sipo_shift #(.W(W)) u_sipo (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .clr   (shift_clr),
    .sin   (sdi),
    .q     (shift_q)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      slot_cnt   <= '0;
      ch_data    <= '0;
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err <= 1'b0;
`endif
    end else begin
      ch_valid   <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
`ifdef TDM_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (sdi_valid) begin
        if (frame_sync) begin
          // A sync inside a frame aborts the partial slot; completed channels
          // keep their values and this bit restarts the frame.
          if (state == ST_RECV && (bit_cnt != '0 || slot_cnt != '0)) begin
            sync_err <= 1'b1;
          end
          state    <= ST_RECV;
          bit_cnt  <= BCW'(1);
          slot_cnt <= '0;
        end else if (state == ST_RECV) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            for (int k = 0; k < N_CH; k++) begin
              if (slot_cnt == SCW'(k)) begin
                ch_data[k*W +: W] <= slot_word;
                ch_valid[k]       <= 1'b1;
              end
            end
`ifdef TDM_PARITY_EN
            // Even parity: data bits plus parity bit must have an even count of ones.
            parity_err <= ^{shift_q, sdi};
`endif
            if (slot_cnt == LAST_SLOT) begin
              slot_cnt   <= '0;
              frame_done <= 1'b1;
              state      <= ST_IDLE;
            end else begin
              slot_cnt <= slot_cnt + SCW'(1);
            end
          end else begin
            bit_cnt <= bit_cnt + BCW'(1);
          end
        end
      end
    end
  end

endmodule
